// File: rtl/fnv_hash_controller.sv
// Command sequencer between an I2C byte interface and an FNV-1a hash core.
// Decodes INIT / FEED / READ opcodes and serialises the hash snapshot back MSB first.
module fnv_hash_controller #(
    parameter int unsigned HASH_W   = 32,
    parameter logic [7:0]  CMD_INIT = 8'hA0,
    parameter logic [7:0]  CMD_FEED = 8'hA1,
    parameter logic [7:0]  CMD_READ = 8'hA2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              rx_ready_o,
    input  logic              i2c_stop_i,
    input  logic              tx_req_i,
    output logic [7:0]        tx_data_o,
    output logic              hash_init_o,
    output logic              hash_en_o,
    output logic [7:0]        hash_byte_o,
    input  logic              hash_busy_i,
    input  logic [HASH_W-1:0] hash_value_i,
    output logic              err_o
);
    localparam int unsigned NumBytes = HASH_W / 8;
    localparam int unsigned IdxW     = $clog2(NumBytes + 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumBytes);

    typedef enum logic [1:0] {StIdle, StLen, StFeed, StErr} state_e;

    state_e            state_q, state_d;
    logic [8:0]        rem_q, rem_d;
    logic              hash_en_q, hash_en_d;
    logic [7:0]        hash_byte_q, hash_byte_d;
    logic              init_pend_q, init_pend_d;
    logic              read_pend_q, read_pend_d;
    logic              armed_q, armed_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [HASH_W-1:0] snap_q, snap_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              err_q, err_d;
    logic              alive_q;
    logic              accept;
    logic [HASH_W-1:0] snap_shift;

    // alive_q keeps rx_ready low while in reset and for the first cycle after release
    always_comb begin
        rx_ready_o = 1'b0;
        case (state_q)
            StFeed:  rx_ready_o = !hash_busy_i && !hash_en_q && (rem_q != 9'd0);
            default: rx_ready_o = 1'b1;
        endcase
        rx_ready_o = rx_ready_o && alive_q;
    end

    assign accept      = rx_valid_i && rx_ready_o;
    assign snap_shift  = snap_q << {idx_q, 3'b000};
    assign hash_init_o = init_pend_q && !hash_busy_i;
    assign hash_en_o   = hash_en_q;
    assign hash_byte_o = hash_byte_q;
    assign tx_data_o   = tx_data_q;
    assign err_o       = err_q;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        hash_en_d   = 1'b0;
        hash_byte_d = hash_byte_q;
        init_pend_d = init_pend_q && hash_busy_i;
        read_pend_d = read_pend_q;
        armed_d     = armed_q;
        idx_d       = idx_q;
        snap_d      = snap_q;
        tx_data_d   = tx_data_q;
        err_d       = err_q;

        if (read_pend_q && !hash_busy_i) begin
            snap_d      = hash_value_i;
            read_pend_d = 1'b0;
        end

        // Readback uses the pre-accept index so a coincident CMD_READ resets it afterwards
        if (tx_req_i) begin
            if (armed_q && (idx_q < LastIdx)) begin
                tx_data_d = snap_shift[HASH_W-1 -: 8];
                idx_d     = idx_q + IdxW'(1);
            end else begin
                tx_data_d = 8'hFF;
            end
        end

        if (accept) begin
            case (state_q)
                StIdle: begin
                    if (rx_data_i == CMD_INIT) begin
                        init_pend_d = 1'b1;
                        err_d       = 1'b0;
                    end else if (rx_data_i == CMD_FEED) begin
                        state_d = StLen;
                    end else if (rx_data_i == CMD_READ) begin
                        read_pend_d = 1'b1;
                        armed_d     = 1'b1;
                        idx_d       = '0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StErr;
                    end
                end
                StLen: begin
                    rem_d   = (rx_data_i == 8'd0) ? 9'd256 : {1'b0, rx_data_i};
                    state_d = StFeed;
                end
                StFeed: begin
                    hash_en_d   = 1'b1;
                    hash_byte_d = rx_data_i;
                    rem_d       = rem_q - 9'd1;
                end
                default: ;
            endcase
        end

        if ((state_q == StFeed) && hash_en_q && (rem_q == 9'd0)) begin
            state_d = StIdle;
        end

        // Stop is applied on top of whatever the coincident byte already did
        if (i2c_stop_i) begin
            if ((state_d == StLen) || ((state_d == StFeed) && (rem_d != 9'd0))) begin
                err_d = 1'b1;
            end
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rem_q       <= 9'd0;
            hash_en_q   <= 1'b0;
            hash_byte_q <= 8'd0;
            init_pend_q <= 1'b0;
            read_pend_q <= 1'b0;
            armed_q     <= 1'b0;
            idx_q       <= '0;
            snap_q      <= '0;
            tx_data_q   <= 8'hFF;
            err_q       <= 1'b0;
            alive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            hash_en_q   <= hash_en_d;
            hash_byte_q <= hash_byte_d;
            init_pend_q <= init_pend_d;
            read_pend_q <= read_pend_d;
            armed_q     <= armed_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            tx_data_q   <= tx_data_d;
            err_q       <= err_d;
            alive_q     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fnv_hash_controller.sv
// Bench for fnv_hash_controller: behavioural FNV-1a core, scoreboards for hash_en bytes
// and readback bytes, a vector table for hash results, and hand sequences for corner cases.
module tb_fnv_hash_controller;
    localparam logic [31:0] Basis = 32'h811C9DC5;
    localparam logic [31:0] Prime = 32'h01000193;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        i2c_stop = 1'b0;
    logic        tx_req = 1'b0;
    logic        hash_busy = 1'b0;
    logic        rx_ready, hash_init, hash_en, err;
    logic [7:0]  tx_data, hash_byte;
    logic [31:0] core_h;

    int          checks = 0;
    int          errors = 0;
    int          en_count = 0;
    int          en0;
    logic [31:0] h;
    logic [7:0]  exp_en_q[$];
    logic [7:0]  exp_tx_q[$];
    logic        tx_seen;

    typedef struct packed {
        logic [7:0]  len;
        logic [63:0] data;
        logic [31:0] exp_hash;
    } vec_t;
    vec_t vecs[4];

    always #5 clk = ~clk;

    fnv_hash_controller u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_valid_i  (rx_valid),
        .rx_data_i   (rx_data),
        .rx_ready_o  (rx_ready),
        .i2c_stop_i  (i2c_stop),
        .tx_req_i    (tx_req),
        .tx_data_o   (tx_data),
        .hash_init_o (hash_init),
        .hash_en_o   (hash_en),
        .hash_byte_o (hash_byte),
        .hash_busy_i (hash_busy),
        .hash_value_i(core_h),
        .err_o       (err)
    );

    function automatic logic [31:0] fnv_step(input logic [31:0] hv, input logic [7:0] b);
        return (hv ^ {24'd0, b}) * Prime;
    endfunction

    function automatic logic [31:0] fnv_bytes(input logic [63:0] d, input int n);
        logic [31:0] hv = Basis;
        for (int i = 0; i < n; i++) hv = fnv_step(hv, d[63-8*i -: 8]);
        return hv;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Behavioural hash core
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)         core_h <= 32'd0;
        else if (hash_init) core_h <= Basis;
        else if (hash_en)   core_h <= fnv_step(core_h, hash_byte);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_seen <= 1'b0;
        else        tx_seen <= tx_req;
    end

    always @(negedge clk) begin
        if (rst_n && hash_en) begin
            en_count++;
            if (exp_en_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL hash_en_unexpected: got pulse with byte %02h required none",
                         hash_byte);
            end else begin
                chk("hash_byte", {24'd0, hash_byte}, {24'd0, exp_en_q.pop_front()});
            end
        end
        if (rst_n && tx_seen) begin
            if (exp_tx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got %02h required no readback", tx_data);
            end else begin
                chk("tx_data", {24'd0, tx_data}, {24'd0, exp_tx_q.pop_front()});
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        #1;
        while (!rx_ready && n < 100) begin
            tick();
            n++;
        end
        if (!rx_ready) begin
            checks++;
            errors++;
            $display("FAIL rx_accept_timeout: rx_ready got 0 required 1 for byte %02h", b);
        end else begin
            tick();
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] b);
        exp_en_q.push_back(b);
        send_byte(b);
        chk("feed_latency", {31'd0, hash_en}, 32'd1);
    endtask

    task automatic tx_pulse(input logic [7:0] e);
        exp_tx_q.push_back(e);
        tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
        tick();
    endtask

    task automatic read_hash(input logic [31:0] e);
        send_byte(8'hA2);
        tick(2);
        for (int i = 0; i < 4; i++) tx_pulse(e[31-8*i -: 8]);
        tx_pulse(8'hFF);
    endtask

    task automatic stop_pulse();
        i2c_stop = 1'b1;
        tick();
        i2c_stop = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        chk({tag, "_tx_data"}, {24'd0, tx_data}, 32'hFF);
        chk({tag, "_hash_en"}, {31'd0, hash_en}, 32'd0);
        chk({tag, "_hash_init"}, {31'd0, hash_init}, 32'd0);
        chk({tag, "_hash_byte"}, {24'd0, hash_byte}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'd0, 64'd0, Basis};
        vecs[1] = '{8'd1, {8'h61, 56'd0}, 32'hE40C292C};
        vecs[2] = '{8'd6, {48'h666F6F626172, 16'd0}, fnv_bytes({48'h666F6F626172, 16'd0}, 6)};
        vecs[3] = '{8'd4, {32'h00FF807F, 32'd0}, fnv_bytes({32'h00FF807F, 32'd0}, 4)};

        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        tick(3);
        rst_n = 1'b1;
        tick(2);

        tx_pulse(8'hFF);

        for (int v = 0; v < 4; v++) begin
            en0 = en_count;
            send_byte(8'hA0);
            if (vecs[v].len != 8'd0) begin
                send_byte(8'hA1);
                send_byte(vecs[v].len);
                for (int i = 0; i < int'(vecs[v].len); i++) send_data(vecs[v].data[63-8*i -: 8]);
            end
            tick(2);
            chk("vec_en_count", en_count - en0, {24'd0, vecs[v].len});
            read_hash(vecs[v].exp_hash);
        end

        // READ accepted together with tx_req: exhausted index still answers FF first
        exp_tx_q.push_back(8'hFF);
        rx_valid = 1'b1;
        rx_data  = 8'hA2;
        tx_req   = 1'b1;
        #1;
        chk("coincident_rx_ready", {31'd0, rx_ready}, 32'd1);
        tick();
        rx_valid = 1'b0;
        tx_req   = 1'b0;
        tick(2);
        for (int i = 0; i < 4; i++) tx_pulse(vecs[3].exp_hash[31-8*i -: 8]);
        tx_pulse(8'hFF);

        // INIT held pending while the core is busy
        hash_busy = 1'b1;
        send_byte(8'hA0);
        chk("init_busy_0", {31'd0, hash_init}, 32'd0);
        tick();
        chk("init_busy_1", {31'd0, hash_init}, 32'd0);
        hash_busy = 1'b0;
        #1;
        chk("init_release", {31'd0, hash_init}, 32'd1);
        tick();
        chk("init_one_pulse", {31'd0, hash_init}, 32'd0);
        read_hash(Basis);

        // FEED with L=0 means 256 bytes; busy injected every third byte
        h = Basis;
        en0 = en_count;
        send_byte(8'hA1);
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            if (i % 3 == 0) begin
                hash_busy = 1'b1;
                #1;
                chk("ready_busy_a", {31'd0, rx_ready}, 32'd0);
                tick();
                chk("ready_busy_b", {31'd0, rx_ready}, 32'd0);
                hash_busy = 1'b0;
            end
            send_data(8'(i));
            h = fnv_step(h, 8'(i));
        end
        tick(2);
        chk("feed256_en_count", en_count - en0, 32'd256);
        chk("feed256_err", {31'd0, err}, 32'd0);
        read_hash(h);

        // Abort mid-FEED
        en0 = en_count;
        send_byte(8'hA1);
        send_byte(8'd5);
        send_data(8'h11);
        send_data(8'h22);
        tick(2);
        stop_pulse();
        chk("abort_err", {31'd0, err}, 32'd1);
        tick(3);
        chk("abort_en_count", en_count - en0, 32'd2);
        send_byte(8'hA0);
        chk("abort_init_clears", {31'd0, err}, 32'd0);

        // Stop coincident with the final data byte: byte first, so no error
        send_byte(8'hA1);
        send_byte(8'd1);
        exp_en_q.push_back(8'h5A);
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        i2c_stop = 1'b1;
        #1;
        chk("last_stop_ready", {31'd0, rx_ready}, 32'd1);
        tick();
        rx_valid = 1'b0;
        i2c_stop = 1'b0;
        chk("last_stop_en", {31'd0, hash_en}, 32'd1);
        tick(2);
        chk("last_stop_err", {31'd0, err}, 32'd0);

        // Illegal opcode: ERR swallows everything until stop
        en0 = en_count;
        send_byte(8'h55);
        chk("bad_cmd_err", {31'd0, err}, 32'd1);
        send_byte(8'hA1);
        send_byte(8'd3);
        send_byte(8'hAA);
        send_byte(8'hA0);
        tick(3);
        chk("err_sticky", {31'd0, err}, 32'd1);
        chk("err_no_en", en_count - en0, 32'd0);
        stop_pulse();
        chk("err_after_stop", {31'd0, err}, 32'd1);
        send_byte(8'hA0);
        chk("err_init_clears", {31'd0, err}, 32'd0);

        // Async reset mid-FEED
        en0 = en_count;
        send_byte(8'hA1);
        send_byte(8'd4);
        send_data(8'h77);
        tick(2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midfeed");
        tick(2);
        rst_n = 1'b1;
        tick(10);
        chk("midfeed_en_count", en_count - en0, 32'd1);
        tx_pulse(8'hFF);

        tick(3);
        chk("en_queue_empty", exp_en_q.size(), 32'd0);
        chk("tx_queue_empty", exp_tx_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
